// File: rtl/eros_obi_pkg.sv
// OBI request channel as seen between a hart and the bus.
package eros_obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

endpackage

// File: rtl/eros_pkg.sv
// Shared voter definitions: FSM states and the supported range of redundant harts.
package eros_pkg;

  localparam int NHARTS_MIN = 2;
  localparam int NHARTS_MAX = 3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DEGRADED,
    ST_RECOVERY,
    ST_HALT
  } voter_state_e;

endpackage

// File: rtl/obi_pair_cmp.sv
// Compares the instruction and data requests of two harts; fields that the bus
// ignores (addr without req, wdata without we) do not count as disagreement.
module obi_pair_cmp
  import eros_obi_pkg::*;
(
  input  obi_req_t instr_a,
  input  obi_req_t instr_b,
  input  obi_req_t data_a,
  input  obi_req_t data_b,
  output logic     equal
);

  function automatic logic bus_eq(input obi_req_t a, input obi_req_t b);
    logic eq;
    eq = (a.req == b.req) && (a.we == b.we) && (a.be == b.be);
    if (a.req && b.req && (a.addr != b.addr)) eq = 1'b0;
    if (a.we && b.we && (a.wdata != b.wdata)) eq = 1'b0;
    return eq;
  endfunction

  assign equal = bus_eq(instr_a, instr_b) && bus_eq(data_a, data_b);

endmodule

// File: rtl/redundancy_voter.sv
// Lock-step voter for 2 or 3 redundant harts: forwards the agreed OBI requests,
// tracks which hart went wrong and runs the recovery handshake.
module redundancy_voter
  import eros_pkg::*;
  import eros_obi_pkg::*;
#(
  parameter int NHARTS = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mode_i,
  input  obi_req_t          core_instr_req_i [NHARTS],
  input  obi_req_t          core_data_req_i  [NHARTS],
  output obi_req_t          voted_instr_req_o,
  output obi_req_t          voted_data_req_o,
  output logic              error_o,
  output logic              uncorrectable_o,
  output logic [NHARTS-1:0] faulty_hart_o,
  output logic [CNT_W-1:0]  mismatch_cnt_o,
  output logic              recovery_req_o,
  input  logic              recovery_ack_i
);

  localparam logic TMR_CAPABLE = (NHARTS == NHARTS_MAX);

  obi_req_t instr_h [3];
  obi_req_t data_h  [3];
  logic     eq01, eq02, eq12;

  // Absent harts read as idle so the voting logic below is written once for three.
  for (genvar h = 0; h < 3; h++) begin : g_hart
    if (h < NHARTS) begin : g_present
      assign instr_h[h] = core_instr_req_i[h];
      assign data_h[h]  = core_data_req_i[h];
    end else begin : g_absent
      assign instr_h[h] = '0;
      assign data_h[h]  = '0;
    end
  end

  obi_pair_cmp u_cmp_01 (
    .instr_a (instr_h[0]),
    .instr_b (instr_h[1]),
    .data_a  (data_h[0]),
    .data_b  (data_h[1]),
    .equal   (eq01)
  );

  if (TMR_CAPABLE) begin : g_tmr_cmp
    obi_pair_cmp u_cmp_02 (
      .instr_a (instr_h[0]),
      .instr_b (instr_h[2]),
      .data_a  (data_h[0]),
      .data_b  (data_h[2]),
      .equal   (eq02)
    );
    obi_pair_cmp u_cmp_12 (
      .instr_a (instr_h[1]),
      .instr_b (instr_h[2]),
      .data_a  (data_h[1]),
      .data_b  (data_h[2]),
      .equal   (eq12)
    );
  end else begin : g_dmr_only
    assign eq02 = 1'b1;
    assign eq12 = 1'b1;
  end

  voter_state_e     state_q, state_d;
  logic             tmr;
  logic             surv_eq;
  logic [1:0]       sel;
  logic             gate;
  logic             mismatch;
  logic             new_fault;
  logic [1:0]       new_fault_idx;
  logic             faulty_vld_q;
  logic [1:0]       faulty_idx_q;
  logic             error_q, uncorr_q, rec_req_q;
  logic [CNT_W-1:0] cnt_q;

  assign tmr = TMR_CAPABLE && mode_i;

  // Mode is only consulted in RUN; once degraded, the surviving pair is voted DMR-style.
  always_comb begin
    state_d       = state_q;
    sel           = 2'd0;
    gate          = 1'b0;
    mismatch      = 1'b0;
    new_fault     = 1'b0;
    new_fault_idx = 2'd0;
    surv_eq       = 1'b1;
    unique case (state_q)
      ST_RUN: begin
        if (!tmr) begin
          if (!eq01) begin
            mismatch = 1'b1;
            gate     = 1'b1;
            state_d  = ST_HALT;
          end
        end else if (!(eq01 && eq02 && eq12)) begin
          mismatch = 1'b1;
          if (eq12 && !eq01 && !eq02) begin
            sel           = 2'd1;
            new_fault     = 1'b1;
            new_fault_idx = 2'd0;
            state_d       = ST_DEGRADED;
          end else if (eq02 && !eq01 && !eq12) begin
            new_fault     = 1'b1;
            new_fault_idx = 2'd1;
            state_d       = ST_DEGRADED;
          end else if (eq01 && !eq02 && !eq12) begin
            new_fault     = 1'b1;
            new_fault_idx = 2'd2;
            state_d       = ST_DEGRADED;
          end else begin
            gate    = 1'b1;
            state_d = ST_HALT;
          end
        end
      end
      ST_DEGRADED, ST_RECOVERY: begin
        case (faulty_idx_q)
          2'd0:    surv_eq = eq12;
          2'd1:    surv_eq = eq02;
          default: surv_eq = eq01;
        endcase
        sel = (faulty_idx_q == 2'd0) ? 2'd1 : 2'd0;
        if (!surv_eq) begin
          mismatch = 1'b1;
          gate     = 1'b1;
          state_d  = ST_HALT;
        end else if (state_q == ST_DEGRADED) begin
          state_d = ST_RECOVERY;
        end else if (recovery_ack_i) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        gate = 1'b1;
        if (recovery_ack_i) state_d = ST_RUN;
      end
      default: begin
        gate    = 1'b1;
        state_d = ST_RUN;
      end
    endcase
  end

  assign voted_instr_req_o = (gate || !rst_ni) ? '0 : instr_h[sel];
  assign voted_data_req_o  = (gate || !rst_ni) ? '0 : data_h[sel];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      error_q      <= 1'b0;
      uncorr_q     <= 1'b0;
      rec_req_q    <= 1'b0;
      cnt_q        <= '0;
      faulty_vld_q <= 1'b0;
      faulty_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      uncorr_q  <= (state_d == ST_HALT);
      rec_req_q <= (state_d == ST_RECOVERY) || (state_d == ST_HALT);
      if (mismatch) error_q <= 1'b1;
      if (mismatch && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
      if (new_fault) begin
        faulty_vld_q <= 1'b1;
        faulty_idx_q <= new_fault_idx;
      end else if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
        faulty_vld_q <= 1'b0;
        faulty_idx_q <= 2'd0;
      end
    end
  end

  always_comb begin
    faulty_hart_o = '0;
    if (faulty_vld_q) faulty_hart_o[faulty_idx_q] = 1'b1;
  end

  assign error_o         = error_q;
  assign uncorrectable_o = uncorr_q;
  assign recovery_req_o  = rec_req_q;
  assign mismatch_cnt_o  = cnt_q;

endmodule

// File: doc/redundancy_voter.md
REDUNDANCY_VOTER -- requirements
Module: redundancy_voter

Interface
REQ-001 SHALL have parameter NHARTS, default 3, number of redundant harts; legal values are 2 or 3.
REQ-002 SHALL have parameter CNT_W, default 8, width of the mismatch event counter.
REQ-003 SHALL have ports in this order: clk_i input 1, the single clock; rst_ni input 1, asynchronous active-low reset.
REQ-004 SHALL have port mode_i input 1: 0 = DMR (harts 0,1 compared), 1 = TMR (harts 0,1,2 voted); mode_i is ignored and treated as 0 when NHARTS=2.
REQ-005 SHALL have ports core_instr_req_i and core_data_req_i, each input obi_req_t[NHARTS], one per-hart OBI request.
REQ-006 SHALL have ports voted_instr_req_o and voted_data_req_o, each output obi_req_t, the request forwarded to the bus.
REQ-007 SHALL have port error_o output 1, sticky fault-present flag.
REQ-008 SHALL have port uncorrectable_o output 1, set while the block is in HALT.
REQ-009 SHALL have port faulty_hart_o output NHARTS, one-hot hart identified as faulty; all zero if unknown.
REQ-010 SHALL have port mismatch_cnt_o output CNT_W, saturating count of mismatch cycles.
REQ-011 SHALL have ports recovery_req_o output 1 and recovery_ack_i input 1, forming the recovery handshake with the safety controller.

Function
REQ-012 Pair equality of two harts SHALL be defined per bus as: req, we and be equal; addr equal when both req=1; wdata equal when both we=1; a pair is equal only if both the instr and the data bus are equal.
REQ-013 DMR: a mismatch SHALL be pair(0,1) unequal; in that cycle both voted outputs SHALL be all-zero and the FSM SHALL go to HALT.
REQ-014 TMR with all pairs equal: the outputs SHALL be hart 0's requests.
REQ-015 TMR with exactly one hart k disagreeing and the other two equal: the outputs SHALL be the request of the lowest-indexed agreeing hart in the same cycle, with no gating, and the FSM SHALL go to DEGRADED with faulty_hart_o = one-hot k.
REQ-016 TMR with no equal pair: the outputs SHALL be all-zero in the same cycle and the FSM SHALL go to HALT.
REQ-017 Gating and voting SHALL be combinational (zero latency); the state, flags and counter SHALL update on the next clk_i rising edge.
REQ-018 FSM states SHALL be RUN, DEGRADED, RECOVERY and HALT.
REQ-019 RUN SHALL go to DEGRADED or HALT as given in REQ-013, REQ-015 and REQ-016.
REQ-020 DEGRADED SHALL go to RECOVERY on the next cycle unconditionally.
REQ-021 In RECOVERY, recovery_req_o SHALL be 1; the FSM SHALL stay in RECOVERY until recovery_ack_i=1, then return to RUN.
REQ-022 In DEGRADED and RECOVERY, voting SHALL continue using only the two non-faulty harts (DMR semantics on that pair); a mismatch between them SHALL force HALT, overriding any pending ack.
REQ-023 HALT: outputs SHALL be all-zero regardless of inputs, uncorrectable_o=1 and recovery_req_o=1; the FSM SHALL leave HALT only via recovery_ack_i=1, going to RUN.
REQ-024 recovery_req_o SHALL be registered and SHALL stay high until the cycle after ack is sampled.
REQ-025 A returning transition to RUN SHALL clear faulty_hart_o and uncorrectable_o; error_o SHALL remain set.
REQ-026 mismatch_cnt_o SHALL increment by 1 every cycle in which any compared pair is unequal, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-027 A mode_i change SHALL take effect only in RUN; in other states the mode is held from FSM entry.

Reset
REQ-028 On rst_ni=0, asynchronously: state=RUN, error_o=0, uncorrectable_o=0, faulty_hart_o=0, mismatch_cnt_o=0, recovery_req_o=0.
REQ-029 Reset asserted mid-RECOVERY or mid-HALT SHALL abort the handshake with no residual request.
REQ-030 Voted outputs during reset SHALL be all-zero.

Structure
REQ-031 The FSM state enum and the NHARTS legality constants SHALL live in eros_pkg; obi_req_t comes from eros_obi_pkg.
REQ-032 Pair equality SHALL be a sub-module obi_pair_cmp (two obi_req_t pairs in, equal out), instantiated once per hart pair.

Verification
REQ-033 TMR, all harts read addr 0x100 -> voted addr 0x100, error_o=0, cnt=0.
REQ-034 TMR, hart 2 data addr 0x204 vs 0x200 -> output addr 0x200 same cycle, faulty_hart_o=3'b100, next cycle recovery_req_o=1, ack -> RUN, error_o stays 1, cnt=1.
REQ-035 DMR, harts 0,1 write wdata 0xA5 vs 0x5A with we=1 -> outputs zero same cycle, HALT, uncorrectable_o=1.
REQ-036 DMR, harts 0,1 with req=0, differing addr and we=0, differing wdata -> no error.
REQ-037 CNT_W=2 with 5 mismatch cycles -> mismatch_cnt_o=3; rst_ni pulse in HALT -> all outputs at reset values.
REQ-038 In DEGRADED, a second mismatch between the surviving pair -> HALT even if recovery_ack_i=1 in that cycle.
